// File: rtl/nios2_ci_core_copy_master_pkg.sv
// Shared definitions for the block-copy Avalon-MM master.
// Holds the FSM state encoding, the byteenable constant and default widths.
// No ports; imported by the interface and the top module.
package nios2_ci_core_copy_pkg;

  localparam int ADDR_W_DEFAULT = 13;  // 8192-word RAM
  localparam int LEN_W_DEFAULT  = 14;  // lengths 0..8192

  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/nios2_ci_core_copy_master_if.sv
// Avalon-MM bus between the copy master and a word-addressed slave.
// master modport: drives address/read/write/byteenable/writedata,
//   receives readdata/waitrequest/readdatavalid. slave modport is the mirror.
interface nios2_ci_core_copy_master_if
  import nios2_ci_core_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );

endinterface

// File: rtl/nios2_ci_core_copy_master.sv
// Purpose: Avalon-MM master copying ctl_len words from ctl_src to ctl_dst, ascending.
// Latency: 3 cycles/word with a zero-wait, 1-cycle-latency slave; done 1 cycle after last write.
// Backpressure: avm_waitrequest holds the current command stable; one read outstanding max.
// Ports: clk/reset (sync, active-high); ctl_* start/busy/done/count control side;
//   avm (master modport) Avalon-MM bus. Define NIOS2_CI_CORE_COPY_FILL_EN to add
//   ctl_fill/ctl_pattern, which write a constant pattern at one word per cycle.
module nios2_ci_core_copy_master
  import nios2_ci_core_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctl_start,
  input  logic [ADDR_W-1:0] ctl_src,
  input  logic [ADDR_W-1:0] ctl_dst,
  input  logic [LEN_W-1:0]  ctl_len,
  input  logic              ctl_abort,
`ifdef NIOS2_CI_CORE_COPY_FILL_EN
  input  logic              ctl_fill,
  input  logic [31:0]       ctl_pattern,
`endif
  output logic              ctl_busy,
  output logic              ctl_done,
  output logic              ctl_aborted,
  output logic [LEN_W-1:0]  ctl_count,
  nios2_ci_core_copy_master_if.master avm
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              abort_q, abort_d;
  logic              aborted_q, aborted_d;
  logic              fill_q, fill_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              abort_now;
  logic              fill_in;
  logic [31:0]       pattern_in;

`ifdef NIOS2_CI_CORE_COPY_FILL_EN
  assign fill_in    = ctl_fill;
  assign pattern_in = ctl_pattern;
`else
  assign fill_in    = 1'b0;
  assign pattern_in = 32'h0;
`endif

  // The live abort input is ORed in so a pulse arriving in the very cycle of a
  // transfer boundary still stops the copy there.
  assign abort_now = abort_q | ctl_abort;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    count_d   = count_q;
    aborted_d = aborted_q;
    fill_d    = fill_q;
    wdata_d   = wdata_q;
    abort_d   = abort_q | (ctl_abort & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (ctl_start) begin
          src_d     = ctl_src;
          dst_d     = ctl_dst;
          rem_d     = ctl_len;
          count_d   = '0;
          aborted_d = 1'b0;
          abort_d   = 1'b0;
          fill_d    = fill_in;
          if (fill_in) wdata_d = pattern_in;
          if (ctl_len == '0)  state_d = DONE;
          else if (fill_in)   state_d = WR_REQ;
          else                state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm.avm_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          wdata_d = avm.avm_readdata;
          if (abort_now) begin
            aborted_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (!avm.avm_waitrequest) begin
          src_d   = src_q + 1'b1;  // wraps modulo 2^ADDR_W
          dst_d   = dst_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          count_d = count_q + 1'b1;
          // Completing the final word wins over a pending abort.
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end else if (abort_now) begin
            aborted_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = fill_q ? WR_REQ : RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
      fill_q    <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      abort_q   <= abort_d;
      aborted_q <= aborted_d;
      fill_q    <= fill_d;
      wdata_q   <= wdata_d;
    end
  end

  // Bus outputs decode straight from the state register, so read and write
  // are mutually exclusive and everything is zero in IDLE.
  assign avm.avm_read       = (state_q == RD_REQ);
  assign avm.avm_write      = (state_q == WR_REQ);
  assign avm.avm_address    = (state_q == RD_REQ) ? src_q :
                              (state_q == WR_REQ) ? dst_q : '0;
  assign avm.avm_byteenable = (avm.avm_read | avm.avm_write) ? BYTEENABLE_ALL : 4'h0;
  assign avm.avm_writedata  = wdata_q;

  assign ctl_busy    = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
  assign ctl_done    = (state_q == DONE);
  assign ctl_aborted = aborted_q;
  assign ctl_count   = count_q;

endmodule

// File: tb/tb_nios2_ci_core_copy_master.sv
// Bench for the block-copy master: Avalon slave RAM with configurable stalls and
// read latency, a memory-image reference model, a vector table and corner sequences.
module tb_nios2_ci_core_copy_master;
  import nios2_ci_core_copy_pkg::*;

  localparam int N = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctl_start, ctl_abort;
  logic [12:0] ctl_src, ctl_dst;
  logic [13:0] ctl_len;
  logic        ctl_busy, ctl_done, ctl_aborted;
  logic [13:0] ctl_count;
`ifdef NIOS2_CI_CORE_COPY_FILL_EN
  logic        ctl_fill;
  logic [31:0] ctl_pattern;
`endif

  nios2_ci_core_copy_master_if #(.ADDR_W(13)) avm_bus ();

  nios2_ci_core_copy_master #(.ADDR_W(13), .LEN_W(14)) dut (
    .clk(clk), .reset(reset), .ctl_start(ctl_start), .ctl_src(ctl_src),
    .ctl_dst(ctl_dst), .ctl_len(ctl_len), .ctl_abort(ctl_abort),
`ifdef NIOS2_CI_CORE_COPY_FILL_EN
    .ctl_fill(ctl_fill), .ctl_pattern(ctl_pattern),
`endif
    .ctl_busy(ctl_busy), .ctl_done(ctl_done), .ctl_aborted(ctl_aborted),
    .ctl_count(ctl_count), .avm(avm_bus)
  );

  always #5 clk = ~clk;

  // ---------------- slave RAM model (acts mid-cycle on the falling edge) ----
  logic [31:0] mem [N];
  logic [31:0] ref_mem [N];
  logic [12:0] rd_log[$], wr_log[$];
  int          stall_max = 0, lat = 1;
  bit          stall_rand = 1'b0;
  int          viol = 0;
  bit          mem_ready = 1'b0;
  int          stall_cnt = 0, cur_stall = 0, pend_cnt = 0;
  logic [31:0] pend_data;
  bit          prev_wait = 1'b0;
  logic [46:0] prev_sig, cur_sig;

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < N; i++) mem[i] = 32'h5A00_0000 | 32'(i);
      for (int k = 0; k < 4; k++) mem[16 + k] = 32'hA0 + 32'(k);
      mem_ready = 1'b1;
    end
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = $urandom;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        avm_bus.avm_readdatavalid = 1'b1;
        avm_bus.avm_readdata      = pend_data;
      end
    end
    if (reset) begin
      prev_wait = 1'b0;
      avm_bus.avm_waitrequest = 1'b0;
    end else if (avm_bus.avm_read || avm_bus.avm_write) begin
      if (avm_bus.avm_read && avm_bus.avm_write) viol++;
      if (avm_bus.avm_byteenable !== 4'hF) viol++;
      cur_sig = {avm_bus.avm_read, avm_bus.avm_write, avm_bus.avm_address,
                 avm_bus.avm_write ? avm_bus.avm_writedata : 32'h0};
      if (prev_wait && cur_sig !== prev_sig) viol++;
      if (!prev_wait) begin
        cur_stall = stall_rand ? $urandom_range(0, stall_max) : stall_max;
        stall_cnt = 0;
      end
      if (stall_cnt < cur_stall) begin
        avm_bus.avm_waitrequest = 1'b1;
        stall_cnt++;
        prev_wait = 1'b1;
      end else begin
        avm_bus.avm_waitrequest = 1'b0;
        prev_wait = 1'b0;
        if (avm_bus.avm_write) begin
          mem[avm_bus.avm_address] = avm_bus.avm_writedata;
          wr_log.push_back(avm_bus.avm_address);
        end else begin
          rd_log.push_back(avm_bus.avm_address);
          pend_data = mem[avm_bus.avm_address];
          pend_cnt  = lat;
        end
      end
      prev_sig = cur_sig;
    end else begin
      avm_bus.avm_waitrequest = 1'($urandom_range(0, 1));
      prev_wait = 1'b0;
    end
  end

  // ---------------- checking helpers ----------------------------------------
  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    ctl_busy, 0);
    check({tag, "_done"},    ctl_done, 0);
    check({tag, "_aborted"}, ctl_aborted, 0);
    check({tag, "_count"},   ctl_count, 0);
    check({tag, "_read"},    avm_bus.avm_read, 0);
    check({tag, "_write"},   avm_bus.avm_write, 0);
    check({tag, "_addr"},    avm_bus.avm_address, 0);
    check({tag, "_be"},      avm_bus.avm_byteenable, 0);
    check({tag, "_wdata"},   avm_bus.avm_writedata, 0);
  endtask

  // Reference: starting from the pre-run image, words are moved one at a time
  // in ascending order (or the pattern stored); addresses wrap at 13 bits.
  task automatic model_check(input string tag, input logic [12:0] src, dst,
                             input int n_rd, n_wr, input bit fill, input logic [31:0] pat,
                             input int rd_base, wr_base, viol_base);
    int bad;
    for (int k = 0; k < n_wr; k++)
      ref_mem[dst + 13'(k)] = fill ? pat : ref_mem[src + 13'(k)];
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    check({tag, "_mem_image"}, bad, 0);
    check({tag, "_rd_cnt"}, rd_log.size() - rd_base, n_rd);
    check({tag, "_wr_cnt"}, wr_log.size() - wr_base, n_wr);
    bad = 0;
    for (int k = 0; k < n_rd && rd_base + k < rd_log.size(); k++)
      if (rd_log[rd_base + k] !== src + 13'(k)) bad++;
    check({tag, "_rd_order"}, bad, 0);
    bad = 0;
    for (int k = 0; k < n_wr && wr_base + k < wr_log.size(); k++)
      if (wr_log[wr_base + k] !== dst + 13'(k)) bad++;
    check({tag, "_wr_order"}, bad, 0);
    check({tag, "_protocol"}, viol - viol_base, 0);
  endtask

  task automatic run_copy(input logic [12:0] src, dst, input logic [13:0] len,
                          input int abort_rd, input bit fill, input logic [31:0] pat,
                          output int busy_c, done_c, done_lat, wr_cyc,
                          output int rd_base, wr_base, viol_base);
    bit abort_sent;
    rd_base = rd_log.size(); wr_base = wr_log.size(); viol_base = viol;
    for (int i = 0; i < N; i++) ref_mem[i] = mem[i];
    busy_c = 0; done_c = 0; done_lat = -1; wr_cyc = 0; abort_sent = 1'b0;
    @(posedge clk); #1;
    ctl_src = src; ctl_dst = dst; ctl_len = len; ctl_start = 1'b1;
`ifdef NIOS2_CI_CORE_COPY_FILL_EN
    ctl_fill = fill; ctl_pattern = pat;
`else
    if (fill || pat != 0) $display("note: fill requested but not built in");
`endif
    @(posedge clk); #1;
    ctl_start = 1'b0;
    // cyc = number of rising edges from raising start to the next edge
    for (int cyc = 2; cyc < 4000; cyc++) begin
      @(negedge clk);
      ctl_start = 1'b0;
      ctl_abort = 1'b0;
      if (cyc == 4 && ctl_busy) begin   // stray start while busy must be ignored
        ctl_start = 1'b1; ctl_src = 13'($urandom); ctl_len = 14'd1;
      end
      if (abort_rd > 0 && !abort_sent && rd_log.size() - rd_base == abort_rd &&
          ctl_busy && !avm_bus.avm_read && !avm_bus.avm_write) begin
        ctl_abort = 1'b1; abort_sent = 1'b1;
      end
      if (ctl_busy) busy_c++;
      if (avm_bus.avm_write) wr_cyc++;
      if (ctl_done) begin
        done_c++;
        if (done_lat < 0) done_lat = cyc;
      end
      if (done_lat >= 0 && cyc >= done_lat + 2) break;
    end
    ctl_start = 1'b0; ctl_abort = 1'b0;
    check("done_seen_within_budget", done_lat >= 0, 1);
  endtask

  // ---------------- vector table --------------------------------------------
  typedef struct {
    logic [12:0] src, dst;
    logic [13:0] len;
    int          stall, lat, abort_rd;
    int          exp_busy, exp_count;
    logic        exp_aborted;
  } vec_t;

  vec_t vt [7];
  int   busy_c, done_c, done_lat, wr_cyc, rb, wb, vb, nrd, hit;
  logic [12:0] rs, rd;
  logic [13:0] rl;

  initial begin
    // busy cycles per word = RD_REQ(stall+1) + RD_WAIT(lat) + WR_REQ(stall+1)
    vt[0] = '{13'h0010, 13'h0100, 14'd4, 0, 1, -1, 12, 4, 1'b0}; // basic copy
    vt[1] = '{13'h0040, 13'h0400, 14'd0, 0, 1, -1,  0, 0, 1'b0}; // zero length
    vt[2] = '{13'h0020, 13'h0200, 14'd2, 3, 1, -1, 18, 2, 1'b0}; // 3-cycle stalls
    vt[3] = '{13'h1FFE, 13'h0000, 14'd4, 0, 1, -1, 12, 4, 1'b0}; // address wrap
    vt[4] = '{13'h0060, 13'h0600, 14'd8, 0, 1,  3,  8, 2, 1'b1}; // abort at 3rd read
    vt[5] = '{13'h0030, 13'h0300, 14'd3, 0, 3, -1, 15, 3, 1'b0}; // 3-cycle read latency
    vt[6] = '{13'h0050, 13'h0052, 14'd5, 1, 2, -1, 30, 5, 1'b0}; // overlap dst>src

    reset = 1'b1; ctl_start = 1'b0; ctl_abort = 1'b0;
    ctl_src = '0; ctl_dst = '0; ctl_len = '0;
`ifdef NIOS2_CI_CORE_COPY_FILL_EN
    ctl_fill = 1'b0; ctl_pattern = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int t = 0; t < 7; t++) begin
      stall_max = vt[t].stall; stall_rand = 1'b0; lat = vt[t].lat;
      run_copy(vt[t].src, vt[t].dst, vt[t].len, vt[t].abort_rd, 1'b0, 32'h0,
               busy_c, done_c, done_lat, wr_cyc, rb, wb, vb);
      check($sformatf("v%0d_done_pulses", t), done_c, 1);
      check($sformatf("v%0d_busy_cycles", t), busy_c, vt[t].exp_busy);
      check($sformatf("v%0d_count", t), ctl_count, vt[t].exp_count);
      check($sformatf("v%0d_aborted", t), ctl_aborted, vt[t].exp_aborted);
      nrd = (vt[t].abort_rd > 0) ? vt[t].abort_rd : int'(vt[t].len);
      model_check($sformatf("v%0d", t), vt[t].src, vt[t].dst, nrd, vt[t].exp_count,
                  1'b0, 32'h0, rb, wb, vb);
      if (vt[t].len == 0) check("zero_len_done_edge", done_lat, 2);
      if (vt[t].src == 13'h0010)
        for (int k = 0; k < 4; k++)
          check($sformatf("basic_ram_%0h", 256 + k), mem[256 + k], 32'hA0 + 32'(k));
      if (vt[t].src == 13'h1FFE) begin
        check("wrap_rd0", rd_log[rb],     13'h1FFE);
        check("wrap_rd1", rd_log[rb + 1], 13'h1FFF);
        check("wrap_rd2", rd_log[rb + 2], 13'h0000);
        check("wrap_rd3", rd_log[rb + 3], 13'h0001);
      end
    end

    // Reset during WR_REQ of word 5, then a fresh copy.
    stall_max = 0; stall_rand = 1'b0; lat = 1;
    @(posedge clk); #1;
    ctl_src = 13'h0700; ctl_dst = 13'h0900; ctl_len = 14'd8; ctl_start = 1'b1;
    @(posedge clk); #1;
    ctl_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 200 && hit == 0; c++) begin
      @(negedge clk);
      if (ctl_count == 14'd4 && avm_bus.avm_write) begin
        reset = 1'b1; hit = 1;
      end
    end
    check("rst_reached_word5", hit, 1);
    @(negedge clk);
    check_all_zero("midrst");
    reset = 1'b0;
    run_copy(13'h0700, 13'h0900, 14'd8, -1, 1'b0, 32'h0,
             busy_c, done_c, done_lat, wr_cyc, rb, wb, vb);
    check("post_rst_done_pulses", done_c, 1);
    check("post_rst_count", ctl_count, 8);
    model_check("post_rst", 13'h0700, 13'h0900, 8, 8, 1'b0, 32'h0, rb, wb, vb);

    // Randomised copies with random stalls and latency.
    for (int r = 0; r < 15; r++) begin
      rs = 13'($urandom); rd = 13'($urandom); rl = 14'($urandom_range(1, 24));
      stall_max = $urandom_range(0, 2); stall_rand = 1'b1; lat = $urandom_range(1, 3);
      run_copy(rs, rd, rl, -1, 1'b0, 32'h0, busy_c, done_c, done_lat, wr_cyc, rb, wb, vb);
      check($sformatf("rnd%0d_done_pulses", r), done_c, 1);
      check($sformatf("rnd%0d_count", r), ctl_count, rl);
      check($sformatf("rnd%0d_aborted", r), ctl_aborted, 0);
      model_check($sformatf("rnd%0d", r), rs, rd, int'(rl), int'(rl), 1'b0, 32'h0, rb, wb, vb);
    end

`ifdef NIOS2_CI_CORE_COPY_FILL_EN
    stall_max = 0; stall_rand = 1'b0; lat = 1;
    run_copy(13'h0000, 13'h1000, 14'd16, -1, 1'b1, 32'hDEADBEEF,
             busy_c, done_c, done_lat, wr_cyc, rb, wb, vb);
    check("fill_write_cycles", wr_cyc, 16);
    check("fill_busy_cycles", busy_c, 16);
    check("fill_done_pulses", done_c, 1);
    check("fill_count", ctl_count, 16);
    model_check("fill", 13'h0000, 13'h1000, 0, 16, 1'b1, 32'hDEADBEEF, rb, wb, vb);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
